// File: rtl/captura_dosis.sv
// captura_dosis
// Turns the keypad key-code stream into a dosing request.
// The operator enters a compartment key (A-D) and a BCD quantity of up to N_DIG digits.
// '*' deletes the last digit. When the buffer is empty, '*' cancels the entry.
// '#' confirms the entry.
// A confirmed entry is held on valido/dato_bcd/compartimento until the scheduler accepts it with listo.
// If no key is accepted for TIMEOUT cycles while an entry is open, the entry is abandoned.
//
// Ports
//   clk            system clock, posedge
//   rst_n          asynchronous active-low reset
//   numeros[4:0]   key code; bit4 marks a one-cycle key event
//   listo          downstream ready
//   valido         confirmed entry available, held until accepted
//   dato_bcd       confirmed quantity, BCD, digit0 = LSD
//   compartimento  confirmed compartment, A=0 .. D=3
//   buf_bcd        live entry buffer for the display
//   n_digitos      digits currently held in buf_bcd
//   error          one-cycle pulse on a rejected key or on timeout
//   estado         00 IDLE, 01 ENTRY, 10 PEND
//
// State | meaning
// IDLE  | waiting for a compartment key
// ENTRY | collecting digits, inactivity timer running
// PEND  | confirmed entry offered downstream, keys ignored
//
// N_DIG must be 2..7 because n_digitos is 3 bits wide.
// TIMEOUT must be >= 2.

module captura_dosis #(
    parameter int N_DIG   = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         numeros,
    input  logic               listo,
    output logic               valido,
    output logic [4*N_DIG-1:0] dato_bcd,
    output logic [1:0]         compartimento,
    output logic [4*N_DIG-1:0] buf_bcd,
    output logic [2:0]         n_digitos,
    output logic               error,
    output logic [1:0]         estado
);

    localparam int              TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   T_RELOAD = TW'(TIMEOUT - 1);
    localparam logic [2:0]      N_MAX    = 3'(N_DIG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ENTRY = 2'b01,
        S_PEND  = 2'b10
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         sel, sel_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [4*N_DIG-1:0] buf_nxt, dato_nxt;
    logic [2:0]         n_nxt;
    logic [1:0]         comp_nxt;
    logic               valido_nxt, error_nxt;

    logic       key_ev, is_digit, is_comp, is_back, is_conf;
    logic [3:0] code;
    logic [TW-1:0] timer_dec;

    assign key_ev   = numeros[4];
    assign code     = numeros[3:0];
    assign is_digit = key_ev && (code <= 4'd9);
    assign is_comp  = key_ev && (code >= 4'd10) && (code <= 4'd13);
    assign is_back  = key_ev && (code == 4'd14);
    assign is_conf  = key_ev && (code == 4'd15);

    // Rejected keys still count as inactivity.
    // The counter therefore keeps running on them and saturates at zero.
    assign timer_dec = (timer == '0) ? '0 : timer - TW'(1);

    assign estado = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            sel           <= '0;
            timer         <= '0;
            buf_bcd       <= '0;
            n_digitos     <= '0;
            dato_bcd      <= '0;
            compartimento <= '0;
            valido        <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nxt;
            sel           <= sel_nxt;
            timer         <= timer_nxt;
            buf_bcd       <= buf_nxt;
            n_digitos     <= n_nxt;
            dato_bcd      <= dato_nxt;
            compartimento <= comp_nxt;
            valido        <= valido_nxt;
            error         <= error_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        timer_nxt  = timer;
        buf_nxt    = buf_bcd;
        n_nxt      = n_digitos;
        dato_nxt   = dato_bcd;
        comp_nxt   = compartimento;
        valido_nxt = valido;
        error_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (is_comp) begin
                    // Codes 0xA..0xD have low bits 10,11,00,01.
                    // Flipping bit1 maps them to A=0 .. D=3.
                    sel_nxt   = code[1:0] ^ 2'b10;
                    buf_nxt   = '0;
                    n_nxt     = '0;
                    timer_nxt = T_RELOAD;
                    state_nxt = S_ENTRY;
                end else if (key_ev) begin
                    error_nxt = 1'b1;
                end
            end

            S_ENTRY: begin
                if (!key_ev) begin
                    if (timer == '0) begin
                        buf_nxt   = '0;
                        n_nxt     = '0;
                        error_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        timer_nxt = timer_dec;
                    end
                end else if (is_digit) begin
                    if (n_digitos < N_MAX) begin
                        buf_nxt   = {buf_bcd[4*N_DIG-5:0], code};
                        n_nxt     = n_digitos + 3'd1;
                        timer_nxt = T_RELOAD;
                    end else begin
                        error_nxt = 1'b1;
                        timer_nxt = timer_dec;
                    end
                end else if (is_back) begin
                    if (n_digitos != 3'd0) begin
                        buf_nxt   = buf_bcd >> 4;
                        n_nxt     = n_digitos - 3'd1;
                        timer_nxt = T_RELOAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (is_comp) begin
                    sel_nxt   = code[1:0] ^ 2'b10;
                    buf_nxt   = '0;
                    n_nxt     = '0;
                    timer_nxt = T_RELOAD;
                end else if (is_conf) begin
                    if (n_digitos == 3'd0) begin
                        error_nxt = 1'b1;
                        timer_nxt = timer_dec;
                    end else begin
                        dato_nxt   = buf_bcd;
                        comp_nxt   = sel;
                        valido_nxt = 1'b1;
                        state_nxt  = S_PEND;
                    end
                end
            end

            S_PEND: begin
                if (valido && listo) begin
                    valido_nxt = 1'b0;
                    buf_nxt    = '0;
                    n_nxt      = '0;
                    state_nxt  = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_captura_dosis.sv
// Bench for captura_dosis.
// It uses directed scenarios for the documented behaviours.
// It then runs a randomized key stream checked against a queue-based reference model.

module tb_captura_dosis;

    localparam int N_DIG   = 4;
    localparam int TIMEOUT = 12;
    localparam int W       = 4 * N_DIG;

    localparam logic [4:0] K_NONE = 5'h00;
    localparam logic [4:0] K_A    = 5'h1A;
    localparam logic [4:0] K_B    = 5'h1B;
    localparam logic [4:0] K_C    = 5'h1C;
    localparam logic [4:0] K_D    = 5'h1D;
    localparam logic [4:0] K_STAR = 5'h1E;
    localparam logic [4:0] K_HASH = 5'h1F;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   numeros;
    logic         listo;
    logic         valido;
    logic [W-1:0] dato_bcd;
    logic [1:0]   compartimento;
    logic [W-1:0] buf_bcd;
    logic [2:0]   n_digitos;
    logic         error;
    logic [1:0]   estado;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    captura_dosis #(.N_DIG(N_DIG), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .numeros(numeros),
        .listo(listo),
        .valido(valido),
        .dato_bcd(dato_bcd),
        .compartimento(compartimento),
        .buf_bcd(buf_bcd),
        .n_digitos(n_digitos),
        .error(error),
        .estado(estado)
    );

    logic [40:0] obs;
    assign obs = {valido, dato_bcd, compartimento, buf_bcd, n_digitos, error, estado};

    // Reference model. Digits are kept in a queue with the most significant digit at the front.
    // m_since counts edges in ENTRY since the last accepted key.
    int           m_state;
    int           m_sel;
    int           m_digs[$];
    int           m_since;
    bit           m_valido;
    logic [W-1:0] m_dato;
    logic [1:0]   m_comp;
    bit           m_err;

    function automatic logic [W-1:0] digs_to_bcd();
        logic [W-1:0] v = '0;
        foreach (m_digs[i]) v = (v << 4) | W'(m_digs[i]);
        return v;
    endfunction

    function automatic logic [40:0] exp_vec();
        return {m_valido, m_dato, m_comp, digs_to_bcd(), 3'(m_digs.size()), m_err, 2'(m_state)};
    endfunction

    function automatic void model_reset();
        m_state  = 0;
        m_sel    = 0;
        m_digs.delete();
        m_since  = 0;
        m_valido = 0;
        m_dato   = '0;
        m_comp   = '0;
        m_err    = 0;
    endfunction

    function automatic void model_step(input logic [4:0] c, input logic l);
        int k;
        bit kv;
        kv    = c[4];
        k     = int'(c[3:0]);
        m_err = 0;
        case (m_state)
            0: begin
                if (kv) begin
                    if (k >= 10 && k <= 13) begin
                        m_sel = k - 10;
                        m_digs.delete();
                        m_since = 0;
                        m_state = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            1: begin
                if (!kv) begin
                    if (m_since >= TIMEOUT - 1) begin
                        m_state = 0;
                        m_digs.delete();
                        m_err = 1;
                    end else begin
                        m_since++;
                    end
                end else if (k <= 9) begin
                    if (m_digs.size() < N_DIG) begin
                        m_digs.push_back(k);
                        m_since = 0;
                    end else begin
                        m_err = 1;
                        m_since++;
                    end
                end else if (k <= 13) begin
                    m_sel = k - 10;
                    m_digs.delete();
                    m_since = 0;
                end else if (k == 14) begin
                    if (m_digs.size() > 0) begin
                        void'(m_digs.pop_back());
                        m_since = 0;
                    end else begin
                        m_state = 0;
                    end
                end else begin
                    if (m_digs.size() == 0) begin
                        m_err = 1;
                        m_since++;
                    end else begin
                        m_dato   = digs_to_bcd();
                        m_comp   = 2'(m_sel);
                        m_valido = 1;
                        m_state  = 2;
                    end
                end
            end
            default: begin
                if (l) begin
                    m_valido = 0;
                    m_digs.delete();
                    m_state = 0;
                end
            end
        endcase
    endfunction

    function automatic logic [4:0] dig(input int d);
        return {1'b1, 4'(d)};
    endfunction

    // One clock cycle. The inputs are applied before the edge.
    // The model advances with the same inputs, and the outputs settle 1 time unit after the edge.
    task automatic tick(input logic [4:0] c, input logic l);
        numeros = c;
        listo   = l;
        @(posedge clk);
        model_step(c, l);
        #1;
        numeros = K_NONE;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        numeros = K_NONE;
        listo   = 1'b0;
        model_reset();
        #12;
        checks++;
        if (obs !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(K_NONE, 1'b0);
        checks++;
        if (estado !== 2'b00 || valido !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: estado=%b valido=%b expected 00/0", estado, valido);
        end
    endtask

    task automatic test_handoff();
        tick(K_B, 1'b0);
        tick(dig(1), 1'b0);
        tick(dig(2), 1'b0);
        tick(K_HASH, 1'b0);
        checks++;
        if ({valido, dato_bcd, compartimento, estado} !== {1'b1, 16'h0012, 2'd1, 2'b10}) begin
            errors++;
            $display("FAIL handoff_offer: valido=%b dato=%h comp=%0d estado=%b expected 1/0012/1/10",
                     valido, dato_bcd, compartimento, estado);
        end
        tick(K_NONE, 1'b1);
        checks++;
        if ({valido, estado, buf_bcd, n_digitos} !== {1'b0, 2'b00, 16'h0000, 3'd0}) begin
            errors++;
            $display("FAIL handoff_accept: valido=%b estado=%b buf=%h n=%0d expected 0/00/0000/0",
                     valido, estado, buf_bcd, n_digitos);
        end
    endtask

    task automatic test_overflow_backspace();
        tick(K_A, 1'b0);
        for (int d = 1; d <= 4; d++) tick(dig(d), 1'b0);
        checks++;
        if ({buf_bcd, n_digitos, error} !== {16'h1234, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL four_digits: buf=%h n=%0d err=%b expected 1234/4/0", buf_bcd, n_digitos, error);
        end
        tick(dig(5), 1'b0);
        checks++;
        if ({buf_bcd, n_digitos, error} !== {16'h1234, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL fifth_digit: buf=%h n=%0d err=%b expected 1234/4/1", buf_bcd, n_digitos, error);
        end
        tick(K_NONE, 1'b0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_width: err=%b expected 0", error);
        end
        tick(K_STAR, 1'b0);
        checks++;
        if ({buf_bcd, n_digitos} !== {16'h0123, 3'd3}) begin
            errors++;
            $display("FAIL backspace: buf=%h n=%0d expected 0123/3", buf_bcd, n_digitos);
        end
        for (int i = 0; i < 4; i++) tick(K_STAR, 1'b0);
        checks++;
        if ({estado, error} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL backspace_exit: estado=%b err=%b expected 00/0", estado, error);
        end
    endtask

    task automatic test_confirm_empty();
        tick(K_C, 1'b0);
        tick(K_HASH, 1'b0);
        checks++;
        if ({estado, error, valido} !== {2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL confirm_empty: estado=%b err=%b valido=%b expected 01/1/0", estado, error, valido);
        end
        tick(K_STAR, 1'b0);
        checks++;
        if ({estado, error} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL cancel_empty: estado=%b err=%b expected 00/0", estado, error);
        end
    endtask

    task automatic test_timeout();
        tick(K_D, 1'b0);
        tick(dig(7), 1'b0);
        repeat (TIMEOUT - 1) tick(K_NONE, 1'b0);
        checks++;
        if ({estado, error} !== {2'b01, 1'b0}) begin
            errors++;
            $display("FAIL timeout_early: estado=%b err=%b expected 01/0", estado, error);
        end
        tick(K_NONE, 1'b0);
        checks++;
        if ({estado, error, buf_bcd, n_digitos} !== {2'b00, 1'b1, 16'h0000, 3'd0}) begin
            errors++;
            $display("FAIL timeout_abort: estado=%b err=%b buf=%h n=%0d expected 00/1/0000/0",
                     estado, error, buf_bcd, n_digitos);
        end
        tick(K_NONE, 1'b0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: err=%b expected 0", error);
        end
        tick(K_D, 1'b0);
        tick(dig(7), 1'b0);
        repeat (TIMEOUT - 1) tick(K_NONE, 1'b0);
        tick(dig(8), 1'b0);
        checks++;
        if ({estado, error, buf_bcd} !== {2'b01, 1'b0, 16'h0078}) begin
            errors++;
            $display("FAIL timeout_key_wins: estado=%b err=%b buf=%h expected 01/0/0078", estado, error, buf_bcd);
        end
        repeat (3) tick(K_STAR, 1'b0);
        checks++;
        if (estado !== 2'b00) begin
            errors++;
            $display("FAIL timeout_cleanup: estado=%b expected 00", estado);
        end
    endtask

    task automatic test_pend_hold();
        tick(K_A, 1'b0);
        tick(dig(9), 1'b0);
        tick(K_HASH, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick({1'b1, 4'($urandom_range(0, 15))}, 1'b0);
            checks++;
            if ({valido, dato_bcd, compartimento, estado, error, buf_bcd} !==
                {1'b1, 16'h0009, 2'd0, 2'b10, 1'b0, 16'h0009}) begin
                errors++;
                $display("FAIL pend_hold[%0d]: valido=%b dato=%h comp=%0d estado=%b err=%b buf=%h",
                         i, valido, dato_bcd, compartimento, estado, error, buf_bcd);
            end
        end
        tick(K_NONE, 1'b1);
        checks++;
        if ({valido, estado} !== {1'b0, 2'b00}) begin
            errors++;
            $display("FAIL pend_release: valido=%b estado=%b expected 0/00", valido, estado);
        end
    endtask

    task automatic test_reset_mid();
        tick(K_A, 1'b0);
        tick(dig(5), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 41'd0) begin
            errors++;
            $display("FAIL reset_mid_entry: got %h expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(K_A, 1'b0);
        tick(dig(1), 1'b0);
        tick(K_HASH, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 41'd0) begin
            errors++;
            $display("FAIL reset_mid_pend: got %h expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(K_NONE, 1'b1);
        checks++;
        if ({valido, estado} !== {1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_drops_pending: valido=%b estado=%b expected 0/00", valido, estado);
        end
    endtask

    task automatic test_random();
        logic [4:0] c;
        logic       l;
        int         pct;
        for (int i = 0; i < 900; i++) begin
            pct = (i < 500) ? 45 : 8;
            if ($urandom_range(0, 99) < pct) c = {1'b1, 4'($urandom_range(0, 15))};
            else                             c = {1'b0, 4'($urandom_range(0, 15))};
            l = ($urandom_range(0, 3) == 0);
            tick(c, l);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_handoff();
        test_overflow_backspace();
        test_confirm_empty();
        test_timeout();
        test_pend_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
